// File: rtl/counter_seq_pkg.sv
// Shared encodings for the command-driven counter sequencer.
package counter_seq_pkg;

   // Command opcodes carried on cmd_op.
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // Sequencer FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2
   } state_t;

endpackage

// File: rtl/updown_load_counter_core.sv
// N-bit up/down counter with synchronous load; acts only when enabled,
// and load takes priority over counting.
module updown_load_counter_core #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         up,
   input  logic         load,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   localparam logic [N-1:0] ONE = 1;

   // Counter register: async clear, then load > up/down when enabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (enable) begin
         if (load)    q <= d;
         else if (up) q <= q + ONE;
         else         q <= q - ONE;
      end
   end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for an up/down/load counter. Accepts one command at a
// time over valid/ready and steers the internal counter core cycle by cycle.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE and does not
// depend on cmd_valid. Fields are captured at that edge and ignored after.
module counter_cmd_sequencer
   import counter_seq_pkg::*;
#(
   parameter int N = 4,
   parameter int L = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_arg,
   input  logic [L-1:0] cmd_steps,
   input  logic         abort,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         done,
   output logic         wrap,
   output logic         aborted,
   output state_t       state_dbg
);

   localparam logic [L-1:0] REM_ONE = 1;

   state_t         state, state_nxt;
   logic [L-1:0]   rem, rem_nxt;
   logic [1:0]     op_q;
   logic [N-1:0]   arg_q;
   logic           done_nxt, wrap_nxt, aborted_nxt;
   logic           core_en, core_up, core_load;
   logic [N-1:0]   core_d;
   logic           accept;

   assign cmd_ready = (state == IDLE);
   assign busy      = !cmd_ready;
   assign accept    = cmd_valid && cmd_ready;
   assign state_dbg = state;

   // State, step counter, latched command and event pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rem     <= '0;
         op_q    <= OP_LOAD;
         arg_q   <= '0;
         done    <= 1'b0;
         wrap    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         state   <= state_nxt;
         rem     <= rem_nxt;
         done    <= done_nxt;
         wrap    <= wrap_nxt;
         aborted <= aborted_nxt;
         if (accept) begin
            op_q  <= cmd_op;
            arg_q <= cmd_arg;
         end
      end
   end

   // Next-state logic and combinational steering of the counter core.
   always_comb begin
      state_nxt   = state;
      rem_nxt     = rem;
      done_nxt    = 1'b0;
      wrap_nxt    = 1'b0;
      aborted_nxt = 1'b0;
      core_en     = 1'b0;
      core_up     = 1'b0;
      core_load   = 1'b0;
      core_d      = arg_q;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == OP_UP || cmd_op == OP_DOWN) begin
                  state_nxt = COUNT;
                  rem_nxt   = cmd_steps;
               end else begin
                  state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            core_en   = 1'b1;
            core_load = 1'b1;
            core_d    = (op_q == OP_CLEAR) ? '0 : arg_q;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         COUNT: begin
            core_up = (op_q == OP_UP);
            if (abort) begin
               aborted_nxt = 1'b1;
               state_nxt   = IDLE;
            end else if (rem == '0) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               core_en  = 1'b1;
               rem_nxt  = rem - REM_ONE;
               wrap_nxt = core_up ? (q == '1) : (q == '0);
               if (rem == REM_ONE) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   updown_load_counter_core #(.N(N)) u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (core_en),
      .up      (core_up),
      .load    (core_load),
      .d       (core_d),
      .q       (q)
   );

endmodule
